// File: rtl/mac_cmd_loop.sv
// mac_cmd_loop: injects a host command word into the UDP RX path
// via a byte FIFO and emulates the UDP TX prepare handshake.
module mac_cmd_loop #(
  parameter int CMD_BYTES  = 12,
  parameter int FIFO_DEPTH = 32,
  parameter int PRNUM      = 10
) (
  input  logic                          gmii_rxc,
  input  logic                          rst_n,
  input  logic                          cmd_make,
  input  logic [8*CMD_BYTES-1:0]        cmd_rx,
  output logic                          cmd_done,
  output logic                          fs_udp_rx,
  input  logic                          fd_udp_rx,
  input  logic                          udp_rxen,
  output logic [7:0]                    udp_rxd,
  output logic [15:0]                   udp_rx_len,
  input  logic                          fs_udp_tx,
  input  logic                          flag_udp_tx_req,
  output logic                          flag_udp_tx_prep,
  input  logic                          fd_udp_tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf
);

  localparam int CW = 8 * CMD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int NW = $clog2(PRNUM + 1) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_LAST = 3'd3;
  localparam logic [2:0] S_WFEX = 3'd4;
  localparam logic [2:0] S_GNEX = 3'd5;
  localparam logic [2:0] S_LTEX = 3'd6;
  localparam logic [2:0] S_LTXX = 3'd7;

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [IW-1:0] idx;
  logic [NW-1:0] wnum;
  logic [CW-1:0] shadow;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr;
  logic          full;
  logic          empty;
  logic          rd_ok;
  logic          wr_ok;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_make)       state_n = S_PREP;
        else if (fs_udp_tx) state_n = S_WFEX;
      end
      S_PREP: if (!cmd_make) state_n = S_LOAD;
      S_LOAD: begin
        if (idx == IW'(CMD_BYTES - 1)) state_n = S_LAST;
      end
      S_LAST: if (fd_udp_rx) state_n = S_IDLE;
      S_WFEX: if (flag_udp_tx_req) state_n = S_GNEX;
      S_GNEX: if (wnum == NW'(PRNUM)) state_n = S_LTEX;
      S_LTEX: if (!flag_udp_tx_req) state_n = S_LTXX;
      S_LTXX: if (fd_udp_tx) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      wnum   <= '0;
      shadow <= '0;
    end else begin
      state <= state_n;
      idx   <= (state == S_LOAD) ? idx + 1'b1 : '0;
      wnum  <= (state == S_GNEX) ? wnum + 1'b1 : '0;
      // byte 0 sits at the top; shift it out one byte per LOAD cycle
      if (state == S_PREP && !cmd_make) shadow <= cmd_rx;
      else if (state == S_LOAD)         shadow <= shadow << 8;
    end
  end

  assign wr    = (state == S_LOAD);
  assign full  = (fifo_level == LW'(FIFO_DEPTH));
  assign empty = (fifo_level == '0);
  assign rd_ok = udp_rxen && !empty;
  // a read on a full FIFO frees the slot this write needs
  assign wr_ok = wr && (!full || rd_ok);

  always_ff @(posedge gmii_rxc) begin
    if (wr_ok) mem[wr_ptr] <= shadow[CW-1 -: 8];
  end

  always_ff @(posedge gmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      udp_rxd    <= '0;
      ovf        <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        udp_rxd <= mem[rd_ptr];
      end
      fifo_level <= fifo_level + LW'(wr_ok) - LW'(rd_ok);
      if (wr && !wr_ok) ovf <= 1'b1;
    end
  end

  assign cmd_done         = (state == S_PREP);
  assign fs_udp_rx        = (state == S_LAST);
  assign flag_udp_tx_prep = (state == S_LTEX);
  assign udp_rx_len       = 16'(CMD_BYTES);

endmodule

// File: tb/tb_mac_cmd_loop.sv
// tb_mac_cmd_loop: randomized scenarios for mac_cmd_loop checked
// against a queue-based byte FIFO model and spec-derived timing.
module tb_mac_cmd_loop;

  localparam int CB    = 12;
  localparam int DEPTH = 16;
  localparam int PRN   = 10;
  localparam int CW    = 8 * CB;

  logic          gmii_rxc = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_make = 1'b0;
  logic [CW-1:0] cmd_rx = '0;
  logic          fd_udp_rx = 1'b0;
  logic          udp_rxen = 1'b0;
  logic          fs_udp_tx = 1'b0;
  logic          flag_udp_tx_req = 1'b0;
  logic          fd_udp_tx = 1'b0;
  logic          cmd_done;
  logic          fs_udp_rx;
  logic [7:0]    udp_rxd;
  logic [15:0]   udp_rx_len;
  logic          flag_udp_tx_prep;
  logic [4:0]    fifo_level;
  logic          ovf;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic [7:0] exp_rxd = 8'h00;
  bit         exp_ovf = 1'b0;
  logic [7:0] obs_q[$];
  logic [7:0] exq[$];
  int         done_n;
  int         gap_n;
  int         ovf_idx;
  bit         prep_seen;
  bit         fs_now;

  mac_cmd_loop #(.CMD_BYTES(CB), .FIFO_DEPTH(DEPTH), .PRNUM(PRN)) dut (
    .gmii_rxc(gmii_rxc), .rst_n(rst_n), .cmd_make(cmd_make),
    .cmd_rx(cmd_rx), .cmd_done(cmd_done), .fs_udp_rx(fs_udp_rx),
    .fd_udp_rx(fd_udp_rx), .udp_rxen(udp_rxen), .udp_rxd(udp_rxd),
    .udp_rx_len(udp_rx_len), .fs_udp_tx(fs_udp_tx),
    .flag_udp_tx_req(flag_udp_tx_req),
    .flag_udp_tx_prep(flag_udp_tx_prep), .fd_udp_tx(fd_udp_tx),
    .fifo_level(fifo_level), .ovf(ovf)
  );

  always #5 gmii_rxc = ~gmii_rxc;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [7:0] byte_of(input logic [CW-1:0] c,
                                         input int i);
    return 8'(c >> (8 * (CB - 1 - i)));
  endfunction

  function automatic logic [CW-1:0] rnd_cmd();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    q.delete();
    exp_rxd = 8'h00;
    exp_ovf = 1'b0;
  endtask

  // One clock: advance the byte-FIFO model with this cycle's actions.
  task automatic tick(input bit wr, input logic [7:0] b);
    bit rd_req;
    @(posedge gmii_rxc);
    rd_req = udp_rxen;
    if (rd_req && q.size() > 0) exp_rxd = q.pop_front();
    if (wr) begin
      if (q.size() < DEPTH) q.push_back(b);
      else exp_ovf = 1'b1;
    end
    #1;
    if (rd_req) begin
      obs_q.push_back(udp_rxd);
      exq.push_back(exp_rxd);
    end
  endtask

  task automatic do_reset();
    cmd_make = 0; fs_udp_tx = 0; flag_udp_tx_req = 0;
    fd_udp_rx = 0; fd_udp_tx = 0; udp_rxen = 0;
    rst_n = 1'b0;
    #1;
    model_clear();
    @(posedge gmii_rxc);
    #1;
    rst_n = 1'b1;
    obs_q.delete();
    exq.delete();
  endtask

  // cmd_make high for nhigh cycles, PREP holds one more, then CB writes.
  task automatic run_cmd(input logic [CW-1:0] cmd, input int nhigh,
                         input bit fs_too, input int rdmode,
                         input int abort_at);
    int k;
    bit wr;
    bit fullrd;
    done_n = 0; gap_n = 0; ovf_idx = -1;
    prep_seen = 0; fullrd = 0;
    cmd_rx = cmd;
    for (int c = 0; c <= nhigh + CB; c++) begin
      k = c - nhigh - 1;
      wr = (k >= 0 && k < CB);
      cmd_make = (c < nhigh);
      fs_udp_tx = fs_too && (c == 0);
      if (rdmode == 1 && q.size() == DEPTH) fullrd = 1;
      if (rdmode == 1) udp_rxen = fullrd;
      else if (rdmode == 2) udp_rxen = 1'($urandom_range(0, 1));
      else udp_rxen = 1'b0;
      if (wr && k == abort_at) begin
        udp_rxen = 1'b0;
        rst_n = 1'b0;
        #1;
        model_clear();
        return;
      end
      tick(wr, wr ? byte_of(cmd, k) : 8'h00);
      if (cmd_done) done_n++;
      else if (done_n > 0 && !fs_udp_rx) gap_n++;
      if (flag_udp_tx_prep) prep_seen = 1;
      if (ovf && ovf_idx < 0 && wr) ovf_idx = k;
    end
    udp_rxen = 1'b0;
    fs_now = fs_udp_rx;
  endtask

  task automatic finish_rx();
    fd_udp_rx = 1'b1;
    tick(0, 8'h00);
    fd_udp_rx = 1'b0;
  endtask

  task automatic drain();
    while (q.size() > 0) begin
      udp_rxen = 1'b1;
      tick(0, 8'h00);
    end
    udp_rxen = 1'b0;
    finish_rx();
  endtask

  task automatic test_reset();
    @(posedge gmii_rxc);
    #1;
    n_cmp++; if ({cmd_done, fs_udp_rx, flag_udp_tx_prep, ovf} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {cmd_done, fs_udp_rx, flag_udp_tx_prep, ovf}); end
    n_cmp++; if (udp_rxd !== 8'h00) begin n_bad++; $display("FAIL reset_rxd: got %h want 00", udp_rxd); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (udp_rx_len !== 16'(CB)) begin n_bad++; $display("FAIL rx_len: got %0d want %0d", udp_rx_len, CB); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [CW-1:0] c;
    c = 96'h0102030405060708090A0B0C;
    do_reset();
    run_cmd(c, 3, 0, 0, -1);
    n_cmp++; if (done_n !== 3) begin n_bad++; $display("FAIL basic_done_cycles: got %0d want 3", done_n); end
    n_cmp++; if (gap_n !== CB) begin n_bad++; $display("FAIL basic_load_cycles: got %0d want %0d", gap_n, CB); end
    n_cmp++; if (fs_now !== 1'b1) begin n_bad++; $display("FAIL basic_fs_udp_rx: got %b want 1", fs_now); end
    n_cmp++; if (fifo_level !== 5'(CB)) begin n_bad++; $display("FAIL basic_level_full: got %0d want %0d", fifo_level, CB); end
    drain();
    n_cmp++; if (obs_q.size() !== CB) begin n_bad++; $display("FAIL basic_nreads: got %0d want %0d", obs_q.size(), CB); end
    for (int i = 0; i < obs_q.size() && i < CB; i++) begin
      n_cmp++; if (obs_q[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL basic_byte%0d: got %h want %h", i, obs_q[i], 8'(i + 1)); end
    end
    n_cmp++; if (fifo_level !== 5'd0) begin n_bad++; $display("FAIL basic_level_empty: got %0d want 0", fifo_level); end
    n_cmp++; if (fs_udp_rx !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got fs_udp_rx=%b want 0", fs_udp_rx); end
  endtask

  task automatic test_tx();
    int n;
    int d;
    fs_udp_tx = 1'b1;
    tick(0, 8'h00);
    fs_udp_tx = 1'b0;
    d = $urandom_range(0, 5);
    repeat (d) tick(0, 8'h00);
    n_cmp++; if (flag_udp_tx_prep !== 1'b0) begin n_bad++; $display("FAIL tx_wfex_prep: got %b want 0", flag_udp_tx_prep); end
    flag_udp_tx_req = 1'b1;
    tick(0, 8'h00);
    n = 0;
    while (!flag_udp_tx_prep && n < 50) begin
      tick(0, 8'h00);
      n++;
    end
    n_cmp++; if (n !== PRN + 1) begin n_bad++; $display("FAIL tx_prep_delay: got %0d want %0d", n, PRN + 1); end
    d = $urandom_range(1, 4);
    repeat (d) tick(0, 8'h00);
    n_cmp++; if (flag_udp_tx_prep !== 1'b1) begin n_bad++; $display("FAIL tx_prep_hold: got %b want 1", flag_udp_tx_prep); end
    flag_udp_tx_req = 1'b0;
    tick(0, 8'h00);
    n_cmp++; if (flag_udp_tx_prep !== 1'b0) begin n_bad++; $display("FAIL tx_prep_drop: got %b want 0", flag_udp_tx_prep); end
    fd_udp_tx = 1'b1;
    tick(0, 8'h00);
    fd_udp_tx = 1'b0;
  endtask

  task automatic test_arbitration();
    int nh;
    nh = $urandom_range(1, 4);
    obs_q.delete(); exq.delete();
    run_cmd(rnd_cmd(), nh, 1, 0, -1);
    n_cmp++; if (done_n !== nh) begin n_bad++; $display("FAIL arb_done_cycles: got %0d want %0d", done_n, nh); end
    n_cmp++; if (fs_now !== 1'b1) begin n_bad++; $display("FAIL arb_fs_udp_rx: got %b want 1", fs_now); end
    drain();
    flag_udp_tx_req = 1'b1;
    repeat (PRN + 4) begin
      tick(0, 8'h00);
      if (flag_udp_tx_prep) prep_seen = 1;
    end
    flag_udp_tx_req = 1'b0;
    n_cmp++; if (prep_seen !== 1'b0) begin n_bad++; $display("FAIL arb_tx_entered: got prep=%b want 0", prep_seen); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exq[i]) begin n_bad++; $display("FAIL arb_byte%0d: got %h want %h", i, obs_q[i], exq[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    run_cmd(rnd_cmd(), $urandom_range(1, 3), 0, 0, -1);
    finish_rx();
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", ovf); end
    run_cmd(rnd_cmd(), $urandom_range(1, 3), 0, 0, -1);
    n_cmp++; if (fifo_level !== 5'(DEPTH)) begin n_bad++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, DEPTH); end
    n_cmp++; if (ovf !== exp_ovf) begin n_bad++; $display("FAIL ovf_flag: got %b want %b", ovf, exp_ovf); end
    n_cmp++; if (ovf_idx !== DEPTH - CB) begin n_bad++; $display("FAIL ovf_first_drop: got %0d want %0d", ovf_idx, DEPTH - CB); end
    drain();
    n_cmp++; if (obs_q.size() !== DEPTH) begin n_bad++; $display("FAIL ovf_nreads: got %0d want %0d", obs_q.size(), DEPTH); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exq[i]) begin n_bad++; $display("FAIL ovf_byte%0d: got %h want %h", i, obs_q[i], exq[i]); end
    end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_full_rw();
    do_reset();
    run_cmd(rnd_cmd(), 1, 0, 0, -1);
    finish_rx();
    run_cmd(rnd_cmd(), $urandom_range(1, 3), 0, 1, -1);
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL fullrw_ovf: got %b want 0", ovf); end
    n_cmp++; if (fifo_level !== 5'(DEPTH)) begin n_bad++; $display("FAIL fullrw_level: got %0d want %0d", fifo_level, DEPTH); end
    drain();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exq[i]) begin n_bad++; $display("FAIL fullrw_byte%0d: got %h want %h", i, obs_q[i], exq[i]); end
    end
  endtask

  task automatic test_midload_reset();
    do_reset();
    run_cmd(rnd_cmd(), 2, 0, 0, 5);
    n_cmp++; if ({cmd_done, fs_udp_rx, flag_udp_tx_prep, ovf} !== 4'b0) begin n_bad++; $display("FAIL midrst_flags: got %b want 0000", {cmd_done, fs_udp_rx, flag_udp_tx_prep, ovf}); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_bad++; $display("FAIL midrst_level: got %0d want 0", fifo_level); end
    n_cmp++; if (udp_rxd !== 8'h00) begin n_bad++; $display("FAIL midrst_rxd: got %h want 00", udp_rxd); end
    @(posedge gmii_rxc);
    #1;
    rst_n = 1'b1;
    obs_q.delete(); exq.delete();
    run_cmd(rnd_cmd(), 2, 0, 0, -1);
    n_cmp++; if (fifo_level !== 5'(CB)) begin n_bad++; $display("FAIL midrst_relevel: got %0d want %0d", fifo_level, CB); end
    drain();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exq[i]) begin n_bad++; $display("FAIL midrst_byte%0d: got %h want %h", i, obs_q[i], exq[i]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int it = 0; it < 6; it++) begin
      run_cmd(rnd_cmd(), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 2, -1);
      n_cmp++; if (fifo_level !== 5'(q.size())) begin n_bad++; $display("FAIL b2b_level%0d: got %0d want %0d", it, fifo_level, q.size()); end
      n_cmp++; if (ovf !== exp_ovf) begin n_bad++; $display("FAIL b2b_ovf%0d: got %b want %b", it, ovf, exp_ovf); end
      if ($urandom_range(0, 1) == 1) drain();
      else finish_rx();
    end
    drain();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exq[i]) begin n_bad++; $display("FAIL b2b_read%0d: got %h want %h", i, obs_q[i], exq[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tx();
    test_arbitration();
    test_overflow();
    test_full_rw();
    test_midload_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
